// File: rtl/reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// reg_load_arbiter
// Round-robin arbiter that sequences single-cycle loads of a shared register.
// Revision: 1.0
// ============================================================================
module reg_load_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   wdata,
    output logic [3:0]           ack,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic [WIDTH-1:0]     reg_in,
    output logic                 reg_load,
    input  logic [WIDTH-1:0]     reg_out,
    output logic [WIDTH-1:0]     rdata,
    output logic [15:0]          load_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam bit         HAS_SETTLE  = (SETTLE_CYCLES > 0);
    localparam logic [7:0] SETTLE_LAST = HAS_SETTLE ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    state_t           state;
    logic [1:0]       ptr;
    logic [7:0]       settle_cnt;
    logic [1:0]       winner;
    logic [1:0]       scan_idx;
    logic [WIDTH-1:0] req_data [4];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_unpack
            assign req_data[g] = wdata[g*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        winner   = ptr;
        scan_idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr + 2'(k);
            if (req[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    assign busy  = (state != ST_IDLE);
    assign rdata = reg_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= 2'd0;
            ack        <= 4'd0;
            grant_id   <= 2'd0;
            reg_in     <= '0;
            reg_load   <= 1'b0;
            load_count <= 16'd0;
            settle_cnt <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        reg_in   <= req_data[winner];
                        grant_id <= winner;
                        ack      <= 4'b0001 << winner;
                        reg_load <= 1'b1;
                        ptr      <= winner + 2'd1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    reg_load   <= 1'b0;
                    ack        <= 4'd0;
                    load_count <= load_count + 16'd1;
                    settle_cnt <= 8'd0;
                    state      <= HAS_SETTLE ? ST_SETTLE : ST_IDLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 8'd0;
                        state      <= ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
